// File: rtl/ex_stage_pipe.sv
// Execute stage with operand forwarding, ALU, branch target and an EX/MEM output register.
// Optional iterative shift-add multiplier for aluop=11 when EX_MUL_UNIT_EN is defined.
module ex_stage_pipe #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        wb_ctl,
    input  logic [2:0]        m_ctl,
    input  logic [1:0]        aluop,
    input  logic              alusrc,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   rdata1,
    input  logic [XLEN-1:0]   rdata2,
    input  logic [XLEN-1:0]   imm,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic              mem_fwd_we,
    input  logic [REG_AW-1:0] mem_fwd_rd,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic              wb_fwd_we,
    input  logic [REG_AW-1:0] wb_fwd_rd,
    input  logic [XLEN-1:0]   wb_fwd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        wb_ctlout,
    output logic              branch,
    output logic              memread,
    output logic              memwrite,
    output logic [XLEN-1:0]   branch_target,
    output logic [XLEN-1:0]   alu_result,
    output logic              zero,
    output logic [XLEN-1:0]   rdata2out,
    output logic [REG_AW-1:0] rd_out,
    output logic              busy,
    output logic              illegal_op
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_val;
    logic [SHW-1:0]  shamt;
    logic            illegal_now;
    logic            accept;
    logic            is_mul;
    logic            mul_done;
    logic [XLEN-1:0] mul_result;

    // MEM result is newer than WB, so it wins; x0 is never forwarded
    always_comb begin
        fwd_a = rdata1;
        if (mem_fwd_we && mem_fwd_rd == rs1 && rs1 != '0)
            fwd_a = mem_fwd_data;
        else if (wb_fwd_we && wb_fwd_rd == rs1 && rs1 != '0)
            fwd_a = wb_fwd_data;
        fwd_b = rdata2;
        if (mem_fwd_we && mem_fwd_rd == rs2 && rs2 != '0)
            fwd_b = mem_fwd_data;
        else if (wb_fwd_we && wb_fwd_rd == rs2 && rs2 != '0)
            fwd_b = wb_fwd_data;
    end

    assign op_b   = alusrc ? imm : fwd_b;
    assign shamt  = op_b[SHW-1:0];
    assign accept = in_valid && in_ready;
    assign in_ready = !busy && (!out_valid || out_ready);

    always_comb begin
        alu_val     = '0;
        illegal_now = 1'b0;
        case (aluop)
            2'b00: alu_val = fwd_a + op_b;
            2'b01: alu_val = fwd_a - op_b;
            2'b10: begin
                case (funct3)
                    3'b000: alu_val = (funct7b5 && !alusrc) ? fwd_a - op_b : fwd_a + op_b;
                    3'b001: alu_val = fwd_a << shamt;
                    3'b010: alu_val = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(op_b)};
                    3'b011: alu_val = {{(XLEN-1){1'b0}}, fwd_a < op_b};
                    3'b100: alu_val = fwd_a ^ op_b;
                    3'b101: alu_val = funct7b5 ? XLEN'($signed(fwd_a) >>> shamt) : fwd_a >> shamt;
                    3'b110: alu_val = fwd_a | op_b;
                    default: alu_val = fwd_a & op_b;
                endcase
            end
            default: begin
`ifndef EX_MUL_UNIT_EN
                illegal_now = 1'b1;
`endif
                alu_val = '0;
            end
        endcase
    end

`ifdef EX_MUL_UNIT_EN
    typedef enum logic {IDLE, MUL} state_t;
    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] acc;
    logic [SHW-1:0]  count;

    assign is_mul     = (aluop == 2'b11);
    assign busy       = (state == MUL);
    assign mul_result = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else begin
            state <= state_next;
            if (accept && is_mul) begin
                mcand  <= fwd_a;
                mplier <= op_b;
                acc    <= '0;
                count  <= '0;
            end else if (state == MUL) begin
                acc    <= mul_result;
                mcand  <= {mcand[XLEN-2:0], 1'b0};
                mplier <= {1'b0, mplier[XLEN-1:1]};
                count  <= count + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        mul_done   = 1'b0;
        case (state)
            IDLE: if (accept && is_mul) state_next = MUL;
            MUL: begin
                if (count == SHW'(XLEN - 1)) begin
                    mul_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end
`else
    assign is_mul     = 1'b0;
    assign busy       = 1'b0;
    assign mul_done   = 1'b0;
    assign mul_result = '0;
`endif

    // Side fields of a multiply are written at accept; the product lands when the loop ends
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            wb_ctlout     <= '0;
            branch        <= 1'b0;
            memread       <= 1'b0;
            memwrite      <= 1'b0;
            branch_target <= '0;
            alu_result    <= '0;
            zero          <= 1'b0;
            rdata2out     <= '0;
            rd_out        <= '0;
            illegal_op    <= 1'b0;
        end else if (accept) begin
            wb_ctlout                    <= wb_ctl;
            {branch, memread, memwrite}  <= m_ctl;
            branch_target                <= pc + imm;
            rdata2out                    <= fwd_b;
            rd_out                       <= rd;
            illegal_op                   <= illegal_now;
            if (is_mul) begin
                out_valid <= 1'b0;
            end else begin
                alu_result <= alu_val;
                zero       <= (alu_val == '0);
                out_valid  <= 1'b1;
            end
        end else if (mul_done) begin
            alu_result <= mul_result;
            zero       <= (mul_result == '0);
            out_valid  <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ex_stage_pipe.sv
// Scoreboard bench for ex_stage_pipe; covers the EX_MUL_UNIT_EN build when that macro is defined.
module tb_ex_stage_pipe;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [1:0]  wb_ctl;
    logic [2:0]  m_ctl;
    logic [1:0]  aluop;
    logic        alusrc;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] pc, rdata1, rdata2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        mem_fwd_we, wb_fwd_we;
    logic [4:0]  mem_fwd_rd, wb_fwd_rd;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic        out_valid, out_ready;
    logic [1:0]  wb_ctlout;
    logic        branch, memread, memwrite;
    logic [31:0] branch_target, alu_result, rdata2out;
    logic        zero;
    logic [4:0]  rd_out;
    logic        busy, illegal_op;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic [31:0] tgt;
        logic [31:0] st;
        logic [4:0]  rd;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic        ill;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    ex_stage_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .wb_ctl(wb_ctl), .m_ctl(m_ctl), .aluop(aluop), .alusrc(alusrc),
        .funct3(funct3), .funct7b5(funct7b5), .pc(pc), .rdata1(rdata1),
        .rdata2(rdata2), .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .out_valid(out_valid), .out_ready(out_ready), .wb_ctlout(wb_ctlout),
        .branch(branch), .memread(memread), .memwrite(memwrite),
        .branch_target(branch_target), .alu_result(alu_result), .zero(zero),
        .rdata2out(rdata2out), .rd_out(rd_out), .busy(busy), .illegal_op(illegal_op)
    );

    function automatic exp_t mk(input logic [31:0] res, input logic [31:0] st, input logic ill);
        exp_t e;
        e.res = res;
        e.z   = (res == 32'd0);
        e.tgt = pc + imm;
        e.st  = st;
        e.rd  = rd;
        e.wb  = wb_ctl;
        e.m   = m_ctl;
        e.ill = ill;
        return e;
    endfunction

    // Reference ALU; b is the already-selected operand B
    function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [2:0] f3,
                                            input logic f7, input logic src,
                                            input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        if (op == 2'b00) return a + b;
        if (op == 2'b01) return a - b;
        if (op == 2'b11) return 32'd0;
        case (f3)
            3'd0: return (f7 && !src) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return f7 ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic clear_inputs();
        in_valid = 0; wb_ctl = 0; m_ctl = 0; aluop = 0; alusrc = 0; funct3 = 0; funct7b5 = 0;
        pc = 0; rdata1 = 0; rdata2 = 0; imm = 0; rs1 = 0; rs2 = 0; rd = 0;
        mem_fwd_we = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
        wb_fwd_we = 0; wb_fwd_rd = 0; wb_fwd_data = 0; out_ready = 1;
    endtask

    // Presents current inputs; pushes the expectation on the accepting edge
    task automatic issue(input exp_t e, input bit push);
        bit done;
        done = 0;
        in_valid = 1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                if (push) sb.push_back(e);
                @(posedge clk); #1;
                done = 1;
            end
        end
        in_valid = 0;
        if (!done) begin
            checks++; errors++;
            $display("[TB] FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
        end
    endtask

    task automatic drain();
        bit done;
        done = 0;
        out_ready = 1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0) done = 1;
        end
        @(posedge clk); #1;
        if (!done) begin
            checks++; errors++;
            $display("[TB] FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, busy, alu_result, zero, illegal_op, branch_target} !== 68'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: valid=%b busy=%b res=%h zero=%b ill=%b tgt=%h, required all 0",
                     out_valid, busy, alu_result, zero, illegal_op, branch_target);
        end
        reset = 0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_sub_latency();
        clear_inputs();
        aluop = 2'b10; funct3 = 3'b000; funct7b5 = 1; alusrc = 0;
        rdata1 = 5; rdata2 = 7; rs1 = 1; rs2 = 2; rd = 4; pc = 32'h100; imm = 32'h20;
        wb_ctl = 2'b01; m_ctl = 3'b010;
        issue(mk(32'hFFFF_FFFE, 32'd7, 0), 1);
        checks++;
        if (out_valid !== 1'b1 || alu_result !== 32'hFFFF_FFFE) begin
            errors++;
            $display("[TB] FAIL sub_latency: valid=%b res=%h, required 1/fffffffe", out_valid, alu_result);
        end
        drain();
    endtask

    task automatic test_forwarding();
        clear_inputs();
        aluop = 2'b00; alusrc = 1; imm = 1; rdata1 = 99; rdata2 = 32'h55;
        rs1 = 3; rs2 = 5; rd = 7; pc = 32'h200;
        mem_fwd_we = 1; mem_fwd_rd = 3; mem_fwd_data = 10;
        wb_fwd_we = 1; wb_fwd_rd = 3; wb_fwd_data = 20;
        issue(mk(32'd11, 32'h55, 0), 1);
        mem_fwd_we = 0;
        issue(mk(32'd21, 32'h55, 0), 1);
        rs1 = 0; rdata1 = 32'h40; mem_fwd_we = 1; mem_fwd_rd = 0; mem_fwd_data = 9;
        wb_fwd_rd = 0; wb_fwd_data = 7;
        issue(mk(32'h41, 32'h55, 0), 1);
        rs1 = 1; rdata1 = 5; rs2 = 3; alusrc = 0;
        mem_fwd_rd = 3; mem_fwd_data = 10; wb_fwd_rd = 3; wb_fwd_data = 20;
        issue(mk(32'd15, 32'd10, 0), 1);
        drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] b;
        clear_inputs();
        for (int i = 0; i < 12; i++) begin
            aluop = (i < 8) ? 2'b10 : 2'($urandom_range(0, 1));
            funct3 = 3'(i);
            funct7b5 = (i == 0 || i == 5) ? 1'b1 : 1'($urandom_range(0, 1));
            alusrc = (i < 8) ? 1'b0 : 1'($urandom_range(0, 1));
            rdata1 = (i < 8) ? 32'hF000_0010 : $urandom;
            rdata2 = (i < 8) ? 32'h0000_0024 : $urandom;
            imm = $urandom; pc = $urandom;
            rs1 = 5'($urandom_range(1, 31)); rs2 = 5'($urandom_range(1, 31)); rd = 5'(i);
            wb_ctl = 2'(i); m_ctl = 3'(i);
            b = alusrc ? imm : rdata2;
            issue(mk(ref_alu(aluop, funct3, funct7b5, alusrc, rdata1, b), rdata2, 0), 1);
        end
        drain();
    endtask

    task automatic test_branch_wrap();
        clear_inputs();
        pc = 32'hFFFF_FFFC; imm = 8; aluop = 2'b01; alusrc = 0;
        rdata1 = 4; rdata2 = 4; rs1 = 1; rs2 = 2; rd = 3; m_ctl = 3'b100;
        issue(mk(32'd0, 32'd4, 0), 1);
        checks++;
        if (branch_target !== 32'h0000_0004 || zero !== 1'b1) begin
            errors++;
            $display("[TB] FAIL branch_wrap: tgt=%h zero=%b, required 00000004/1", branch_target, zero);
        end
        drain();
    endtask

    task automatic test_backpressure();
        clear_inputs();
        out_ready = 0;
        aluop = 2'b00; rdata1 = 100; rdata2 = 23; rs1 = 1; rs2 = 2; rd = 8; pc = 32'h10; imm = 4;
        issue(mk(32'd123, 32'd23, 0), 1);
        aluop = 2'b10; funct3 = 3'b110; rdata1 = 32'h0F00; rdata2 = 32'h00F0; rd = 9;
        in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || alu_result !== 32'd123 || rd_out !== 5'd8) begin
                errors++;
                $display("[TB] FAIL hold_%0d: in_ready=%b valid=%b res=%0d rd=%0d, required 0/1/123/8",
                         i, in_ready, out_valid, alu_result, rd_out);
            end
        end
        @(posedge clk); #1;
        out_ready = 1;
        issue(mk(32'h0FF0, 32'h00F0, 0), 1);
        checks++;
        if (out_valid !== 1'b1 || alu_result !== 32'h0FF0) begin
            errors++;
            $display("[TB] FAIL release: valid=%b res=%h, required 1/00000ff0", out_valid, alu_result);
        end
        drain();
    endtask

`ifdef EX_MUL_UNIT_EN
    task automatic test_mul();
        int busy_cycles;
        int wait_cycles;
        bit seen;
        clear_inputs();
        aluop = 2'b11; rdata1 = 32'hFFFF_FFFF; rdata2 = 3; rs1 = 1; rs2 = 2; rd = 6;
        pc = 32'h80; imm = 32'h8; wb_ctl = 2'b10;
        issue(mk(32'hFFFF_FFFD, 32'd3, 0), 1);
        busy_cycles = 0; wait_cycles = 0; seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            wait_cycles++;
            if (out_valid) seen = 1;
            else if (busy && !in_ready) busy_cycles++;
        end
        checks++;
        if (busy_cycles != 32 || wait_cycles != 33 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mul_timing: busy=%0d wait=%0d busy_now=%b, required 32/33/0",
                     busy_cycles, wait_cycles, busy);
        end
        drain();
        issue(mk(32'd0, 32'd0, 0), 0);
        repeat (9) @(posedge clk);
        #1 reset = 1;
        @(posedge clk); #1;
        reset = 0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mul_reset: busy=%b valid=%b, required 0/0", busy, out_valid);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("[TB] FAIL mul_abandon: output or busy appeared after reset, required none");
        end
    endtask
`else
    task automatic test_illegal();
        clear_inputs();
        aluop = 2'b11; wb_ctl = 2'b11; m_ctl = 3'b101; rd = 9; rs1 = 1; rs2 = 2;
        rdata1 = 32'h77; rdata2 = 32'h1234; pc = 32'h40; imm = 32'h10;
        issue(mk(32'd0, 32'h1234, 1), 1);
        checks++;
        if (busy !== 1'b0 || illegal_op !== 1'b1) begin
            errors++;
            $display("[TB] FAIL illegal_op: busy=%b ill=%b, required 0/1", busy, illegal_op);
        end
        drain();
    endtask
`endif

    initial begin
        clear_inputs();
        reset = 1;
        fork
            forever begin
                @(negedge clk);
                if (!reset && out_valid && out_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_output: res=%h, required no output", alu_result);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        if (alu_result !== e.res || zero !== e.z || illegal_op !== e.ill) begin
                            errors++;
                            $display("[TB] FAIL result: res=%h zero=%b ill=%b, required %h/%b/%b",
                                     alu_result, zero, illegal_op, e.res, e.z, e.ill);
                        end
                        checks++;
                        if (branch_target !== e.tgt || rdata2out !== e.st || rd_out !== e.rd ||
                            wb_ctlout !== e.wb || {branch, memread, memwrite} !== e.m) begin
                            errors++;
                            $display("[TB] FAIL fields: tgt=%h st=%h rd=%0d wb=%b m=%b, required %h/%h/%0d/%b/%b",
                                     branch_target, rdata2out, rd_out, wb_ctlout,
                                     {branch, memread, memwrite}, e.tgt, e.st, e.rd, e.wb, e.m);
                        end
                    end
                end
            end
        join_none
        test_reset();
        test_sub_latency();
        test_forwarding();
        test_back_to_back();
        test_branch_wrap();
        test_backpressure();
`ifdef EX_MUL_UNIT_EN
        test_mul();
`else
        test_illegal();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
